// File: rtl/ro_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency monitor.
package ro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        DONE
    } ro_mon_state_t;

    localparam int RO_N_CH_DEF        = 4;
    localparam int RO_CNT_W_DEF       = 16;
    localparam int RO_WIN_W_DEF       = 16;
    localparam int RO_SETTLE_CYC_DEF  = 8;
    localparam int RO_SYNC_STAGES_DEF = 2;

    // Width of a channel index; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Synchroniser for one asynchronous RO output, followed by a rising-edge detector.
module ro_sync_edge
    import ro_pkg::*;
#(
    parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the async input through the synchroniser; prev keeps the last synchronised sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ro_freq_monitor.sv
// Gated ring-oscillator frequency monitor: enables one RO channel, lets it settle,
// then counts its synchronised rising edges over a programmable window.
module ro_freq_monitor
    import ro_pkg::*;
#(
    parameter int N_CH        = RO_N_CH_DEF,
    parameter int CNT_W       = RO_CNT_W_DEF,
    parameter int WIN_W       = RO_WIN_W_DEF,
    parameter int SETTLE_CYC  = RO_SETTLE_CYC_DEF,
    parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF,
    localparam int SEL_W      = sel_width(N_CH)
) (
    input  logic             ro_clk,
    input  logic             ro_rst,
    input  logic             ro_start,
    input  logic             ro_abort,
    input  logic [SEL_W-1:0] ro_sel,
    input  logic [WIN_W-1:0] ro_win,
    input  logic [N_CH-1:0]  ro_osc_i,
    output logic [N_CH-1:0]  ro_en,
    output logic             ro_busy,
    output logic             ro_done,
    output logic [CNT_W-1:0] ro_cnt,
    output logic             ro_ovf,
    output logic [SEL_W-1:0] ro_ch_q
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]   N_CH_LIM    = (SEL_W + 1)'(N_CH);

    ro_mon_state_t    state, state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [WIN_W-1:0] win_q;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] cnt_w, cnt_nxt;
    logic             ovf_w, ovf_nxt;
    logic             start_ok;
    logic             capture;
    logic             osc_sel;
    logic             rise;

    // Select the latched channel ahead of the single synchroniser instance.
    always_comb begin
        osc_sel = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                osc_sel = ro_osc_i[i];
            end
        end
    end

    ro_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (ro_clk),
        .rst  (ro_rst),
        .din  (osc_sel),
        .rise (rise)
    );

    // Next state, shared settle/window down-counter and saturating edge count.
    // The timer is loaded with N-1 so each phase occupies exactly N cycles.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        cnt_nxt   = cnt_w;
        ovf_nxt   = ovf_w;
        start_ok  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (ro_start && ({1'b0, ro_sel} < N_CH_LIM)) begin
                    start_ok  = 1'b1;
                    state_nxt = ARM;
                    tmr_nxt   = SETTLE_LOAD;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            ARM: begin
                if (ro_abort) begin
                    state_nxt = IDLE;
                end else if (tmr == '0) begin
                    if (win_q == '0) begin
                        state_nxt = DONE;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = MEASURE;
                        tmr_nxt   = TMR_W'(win_q) - TMR_W'(1);
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            MEASURE: begin
                if (ro_abort) begin
                    state_nxt = IDLE;
                end else begin
                    if (rise) begin
                        if (cnt_w == '1) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt_w + CNT_W'(1);
                        end
                    end
                    if (tmr == '0) begin
                        state_nxt = DONE;
                        capture   = 1'b1;
                    end else begin
                        tmr_nxt = tmr - TMR_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and working registers.
    always_ff @(posedge ro_clk) begin
        if (ro_rst) begin
            state <= IDLE;
            tmr   <= '0;
            cnt_w <= '0;
            ovf_w <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            cnt_w <= cnt_nxt;
            ovf_w <= ovf_nxt;
        end
    end

    // Latch channel and window when a valid request is accepted.
    always_ff @(posedge ro_clk) begin
        if (ro_rst) begin
            sel_q <= '0;
            win_q <= '0;
        end else if (start_ok) begin
            sel_q <= ro_sel;
            win_q <= ro_win;
        end
    end

    // Result registers load on entry to DONE (including the final window cycle's edge)
    // so they are already valid while ro_done is high.
    always_ff @(posedge ro_clk) begin
        if (ro_rst) begin
            ro_cnt  <= '0;
            ro_ovf  <= 1'b0;
            ro_ch_q <= '0;
        end else if (capture) begin
            ro_cnt  <= cnt_nxt;
            ro_ovf  <= ovf_nxt;
            ro_ch_q <= sel_q;
        end
    end

    // Status outputs decoded from state; enable is one-hot on the latched channel.
    always_comb begin
        ro_busy = (state == ARM) || (state == MEASURE);
        ro_done = (state == DONE);
        ro_en   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ro_en[i] = ro_busy && (sel_q == SEL_W'(i));
        end
    end

endmodule
